// File: rtl/nodf_module_if.sv
// Passive monitor for the ap_start/ap_ready/ap_done/ap_continue handshake.
// Define NODF_MON_STATS_EN to add min_latency/max_latency outputs.
module nodf_module_if #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] in_flight,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] last_interval,
    output logic [CNT_W-1:0] stall_cnt,
`ifdef NODF_MON_STATS_EN
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
`endif
    output logic             protocol_err,
    output logic             finished
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READY = 2'd1,
        ACTIVE     = 2'd2,
        FINISHED   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAXV = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == MAXV) ? x : x + 1'b1;
    endfunction

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] st_raw;
    logic [CNT_W-1:0] dn_raw;
    logic [CNT_W-1:0] st_raw_n;
    logic [CNT_W-1:0] dn_raw_n;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] itv_cnt;
    logic [CNT_W-1:0] lat_cap;
    logic [CNT_W-1:0] itv_cap;
    logic             seen_start;
    logic             acc;
    logic             cmp;
    logic             err;

    assign state = state_q;

    always_comb begin
        acc      = ap_start & ap_ready;
        cmp      = ap_done & ap_continue;
        st_raw_n = st_raw + {{(CNT_W-1){1'b0}}, acc};
        dn_raw_n = dn_raw + {{(CNT_W-1){1'b0}}, cmp};
        // the counter holds cycles-minus-one since the start, hence the +1
        lat_cap  = acc ? '0 : sat_inc(lat_cnt);
        itv_cap  = sat_inc(itv_cnt);
        err      = (cmp & ~acc & (in_flight == '0))
                 | ((state_q == WAIT_READY) & ~ap_start);
        state_n  = IDLE;
        if (ap_start & ~ap_ready)
            state_n = WAIT_READY;
        else if (st_raw_n != dn_raw_n)
            state_n = ACTIVE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            st_raw        <= '0;
            dn_raw        <= '0;
            start_cnt     <= '0;
            done_cnt      <= '0;
            in_flight     <= '0;
            last_latency  <= '0;
            last_interval <= '0;
            stall_cnt     <= '0;
            lat_cnt       <= '0;
            itv_cnt       <= '0;
            seen_start    <= 1'b0;
            protocol_err  <= 1'b0;
            finished      <= 1'b0;
`ifdef NODF_MON_STATS_EN
            min_latency   <= '1;
            max_latency   <= '0;
`endif
        end else if (finish || state_q == FINISHED) begin
            state_q  <= FINISHED;
            finished <= 1'b1;
        end else begin
            state_q   <= state_n;
            st_raw    <= st_raw_n;
            dn_raw    <= dn_raw_n;
            in_flight <= st_raw_n - dn_raw_n;
            lat_cnt   <= acc ? '0 : sat_inc(lat_cnt);
            itv_cnt   <= acc ? '0 : sat_inc(itv_cnt);
            if (acc) begin
                start_cnt  <= sat_inc(start_cnt);
                seen_start <= 1'b1;
                if (seen_start)
                    last_interval <= itv_cap;
            end
            if (cmp) begin
                done_cnt     <= sat_inc(done_cnt);
                last_latency <= lat_cap;
`ifdef NODF_MON_STATS_EN
                if (lat_cap < min_latency)
                    min_latency <= lat_cap;
                if (lat_cap > max_latency)
                    max_latency <= lat_cap;
`endif
            end
            if (ap_done & ~ap_continue)
                stall_cnt <= sat_inc(stall_cnt);
            if (err)
                protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nodf_module_if.sv
// Directed self-checking bench for nodf_module_if.
module tb_nodf_module_if;

    localparam int CNT_W = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             finish;
    logic [1:0]       state;
    logic [CNT_W-1:0] start_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] last_latency;
    logic [CNT_W-1:0] last_interval;
    logic [CNT_W-1:0] stall_cnt;
`ifdef NODF_MON_STATS_EN
    logic [CNT_W-1:0] min_latency;
    logic [CNT_W-1:0] max_latency;
`endif
    logic             protocol_err;
    logic             finished;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    nodf_module_if #(.CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .finish       (finish),
        .state        (state),
        .start_cnt    (start_cnt),
        .done_cnt     (done_cnt),
        .in_flight    (in_flight),
        .last_latency (last_latency),
        .last_interval(last_interval),
        .stall_cnt    (stall_cnt),
`ifdef NODF_MON_STATS_EN
        .min_latency  (min_latency),
        .max_latency  (max_latency),
`endif
        .protocol_err (protocol_err),
        .finished     (finished)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // start accepted at edge E, done at edge E+k
    task automatic txn(input int k);
        ap_start = 1; ap_ready = 1;
        step();
        ap_start = 0; ap_ready = 0;
        step(k - 1);
        ap_done = 1; ap_continue = 1;
        step();
        ap_done = 0; ap_continue = 0;
    endtask

    initial begin
        reset = 0; ap_start = 0; ap_ready = 0;
        ap_done = 0; ap_continue = 0; finish = 0;
        step(2);
        chk("rst_state", state, 0);
        chk("rst_start", start_cnt, 0);
        chk("rst_err", protocol_err, 0);
`ifdef NODF_MON_STATS_EN
        chk("rst_min", min_latency, 64'hffff_ffff);
        chk("rst_max", max_latency, 0);
`endif
        reset = 1;
        step();

        // single transaction
        ap_start = 1;
        step();
        chk("t1_wait", state, 1);
        step(2);
        ap_ready = 1;
        step();
        chk("t1_active", state, 2);
        chk("t1_inflight", in_flight, 1);
        chk("t1_no_itv", last_interval, 0);
        ap_start = 0; ap_ready = 0;
        step(3);
        ap_done = 1; ap_continue = 1;
        step();
        ap_done = 0; ap_continue = 0;
        chk("t1_idle", state, 0);
        chk("t1_start", start_cnt, 1);
        chk("t1_done", done_cnt, 1);
        chk("t1_lat", last_latency, 4);
        chk("t1_err", protocol_err, 0);

        // back-to-back: starts 6 apart, each latency 4
        txn(4);
        chk("b2b_lat0", last_latency, 4);
        step();
        ap_start = 1; ap_ready = 1;
        step();
        chk("b2b_itv", last_interval, 6);
        chk("b2b_start", start_cnt, 3);
        ap_start = 0; ap_ready = 0;
        step(3);
        ap_done = 1; ap_continue = 1;
        step();
        ap_done = 0; ap_continue = 0;
        chk("b2b_lat1", last_latency, 4);
        chk("b2b_inflight", in_flight, 0);
        chk("b2b_done", done_cnt, 3);

        // backpressure
        ap_start = 1; ap_ready = 1;
        step();
        ap_start = 0; ap_ready = 0;
        step();
        ap_done = 1; ap_continue = 0;
        step(3);
        chk("bp_stall", stall_cnt, 3);
        chk("bp_done_hold", done_cnt, 3);
        ap_continue = 1;
        step();
        ap_done = 0; ap_continue = 0;
        chk("bp_done", done_cnt, 4);
        chk("bp_stall2", stall_cnt, 3);
        chk("bp_lat", last_latency, 5);
        step();
        chk("bp_done_once", done_cnt, 4);

        // done with nothing in flight
        ap_done = 1; ap_continue = 1;
        step();
        ap_done = 0; ap_continue = 0;
        chk("pe1_set", protocol_err, 1);
        step(2);
        chk("pe1_hold", protocol_err, 1);
        reset = 0;
        step();
        reset = 1;
        chk("pe1_rst", protocol_err, 0);
        chk("pe1_rst_if", in_flight, 0);

        // start withdrawn before ready
        ap_start = 1;
        step();
        ap_start = 0;
        step();
        chk("pe2_set", protocol_err, 1);
        chk("pe2_state", state, 0);
        step();
        chk("pe2_hold", protocol_err, 1);
        reset = 0;
        step();
        reset = 1;

        // finish mid-transaction, done on the finish edge is ignored
        ap_start = 1; ap_ready = 1;
        step();
        ap_start = 0; ap_ready = 0;
        step();
        finish = 1; ap_done = 1; ap_continue = 1;
        step();
        finish = 0;
        chk("fin_state", state, 3);
        chk("fin_flag", finished, 1);
        chk("fin_done_edge", done_cnt, 0);
        step();
        chk("fin_done_after", done_cnt, 0);
        ap_done = 0; ap_continue = 0;
        ap_start = 1; ap_ready = 1;
        step();
        ap_start = 0; ap_ready = 0;
        chk("fin_start", start_cnt, 1);
        chk("fin_inflight", in_flight, 1);
        reset = 0;
        step();
        reset = 1;
        chk("frst_state", state, 0);
        chk("frst_flag", finished, 0);
        chk("frst_start", start_cnt, 0);
        chk("frst_if", in_flight, 0);
        chk("frst_lat", last_latency, 0);
        chk("frst_itv", last_interval, 0);
        chk("frst_stall", stall_cnt, 0);

        // latency statistics
        txn(4);
        txn(7);
        txn(2);
        chk("st_lat", last_latency, 2);
        chk("st_done", done_cnt, 3);
        chk("st_start", start_cnt, 3);
`ifdef NODF_MON_STATS_EN
        chk("st_min", min_latency, 2);
        chk("st_max", max_latency, 7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
